// File: rtl/window_lb_pkg.sv
// Shared types and helpers for the sliding-window line buffer.
// Contents:
//   cnt_w()            - counter/address width for a range of n values (min 1)
//   DEF_*              - default geometry used by the typedefs below
//   X_W, Y_W           - column/row counter widths for the default geometry
//   pixel_t            - CH channels of DATA_W bits, channel 0 in the LSBs
//   column_t, window_t - KERNEL_W pixels / KERNEL_W columns
// Modules re-derive the same shapes from their own parameters so that
// non-default instances (e.g. CH=3) keep consistent layouts.
package window_lb_pkg;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_CH       = 1;
  localparam int DEF_KERNEL_W = 3;
  localparam int DEF_IMG_W    = 640;
  localparam int DEF_IMG_H    = 480;

  localparam int X_W = cnt_w(DEF_IMG_W);
  localparam int Y_W = cnt_w(DEF_IMG_H);

  typedef logic [DEF_CH-1:0][DEF_DATA_W-1:0] pixel_t;
  typedef pixel_t [DEF_KERNEL_W-1:0]         column_t;
  typedef column_t [DEF_KERNEL_W-1:0]        window_t;

endpackage

// File: rtl/line_ram.sv
// Single-clock line memory: one synchronous write port, asynchronous read.
// Read and write share one address; a read in the cycle of a write to the
// same address returns the old contents. Contents are not reset.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   addr_i   read/write address
//   wdata_i  write data
//   rdata_o  asynchronous read data at addr_i
module line_ram
  import window_lb_pkg::*;
#(
  parameter int DEPTH  = 640,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = cnt_w(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[addr_i] <= wdata_i;
  end

  assign rdata_o = r_mem[addr_i];

endmodule

// File: rtl/window_linebuffer.sv
// Sliding KERNEL_W x KERNEL_W window generator over a raster pixel stream.
// KERNEL_W-1 line RAMs hold the previous lines; a register array holds the
// current window, emitted only when it lies fully inside the frame.
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   data_i           input pixel, channel c at [c*DATA_W +: DATA_W]
//   valid_i, sof_i   input valid, start of frame for the accepted pixel
//   ready_o          block can accept a pixel
//   window_o         window, element [r][c] at ((r*KERNEL_W+c)*CH*DATA_W)
//                    with r=0 oldest line, c=0 oldest column
//   valid_o, ready_i output handshake
//   eol_o, eof_o     last window of its row / of the frame
module window_linebuffer
  import window_lb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CH       = 1,
  parameter int KERNEL_W = 3,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic [CH*DATA_W-1:0]                data_i,
  input  logic                                valid_i,
  input  logic                                sof_i,
  output logic                                ready_o,
  output logic [KERNEL_W*KERNEL_W*CH*DATA_W-1:0] window_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic                                eol_o,
  output logic                                eof_o
);

  localparam int PIX_W = CH * DATA_W;
  localparam int LX_W  = cnt_w(IMG_W);
  localparam int LY_W  = cnt_w(IMG_H);

  localparam logic [LX_W-1:0] X_LAST = LX_W'(IMG_W - 1);
  localparam logic [LY_W-1:0] Y_LAST = LY_W'(IMG_H - 1);
  localparam logic [LX_W-1:0] X_K1   = LX_W'(KERNEL_W - 1);
  localparam logic [LY_W-1:0] Y_K1   = LY_W'(KERNEL_W - 1);

  logic [LX_W-1:0] r_x;
  logic [LY_W-1:0] r_y;
  logic [LX_W-1:0] w_x;
  logic [LY_W-1:0] w_y;
  logic            w_acc;
  logic            w_eol;

  logic [KERNEL_W-1:0][KERNEL_W-1:0][PIX_W-1:0] r_win;
  logic r_valid, r_eol, r_eof;

  logic [PIX_W-1:0] w_rd [KERNEL_W-1];

  // Single output register: a new window may replace the current one in
  // the same cycle it is taken downstream.
  assign ready_o = !r_valid || ready_i;
  assign w_acc   = valid_i && ready_o;

  // sof_i re-anchors the accepted pixel to the frame origin.
  assign w_x   = sof_i ? '0 : r_x;
  assign w_y   = sof_i ? '0 : r_y;
  assign w_eol = (w_x == X_LAST);

  // Line k holds the line k+1 above the current one; on acceptance each
  // line passes its old value one line further down.
  for (genvar k = 0; k < KERNEL_W - 1; k++) begin : g_line
    logic [PIX_W-1:0] w_wr;
    if (k == 0) begin : g_first
      assign w_wr = data_i;
    end else begin : g_rest
      assign w_wr = w_rd[k-1];
    end
    line_ram #(
      .DEPTH  (IMG_W),
      .WIDTH  (PIX_W),
      .ADDR_W (LX_W)
    ) u_ram (
      .clk_i   (clk_i),
      .we_i    (w_acc),
      .addr_i  (w_x),
      .wdata_i (w_wr),
      .rdata_o (w_rd[k])
    );
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_x     <= '0;
      r_y     <= '0;
      r_win   <= '0;
      r_valid <= 1'b0;
      r_eol   <= 1'b0;
      r_eof   <= 1'b0;
    end else if (w_acc) begin
      if (w_eol) begin
        r_x <= '0;
        r_y <= (w_y == Y_LAST) ? '0 : w_y + LY_W'(1);
      end else begin
        r_x <= w_x + LX_W'(1);
        r_y <= w_y;
      end
      for (int r = 0; r < KERNEL_W; r++) begin
        for (int c = 0; c < KERNEL_W - 1; c++) begin
          r_win[r][c] <= r_win[r][c+1];
        end
      end
      // Newest column: oldest line (last RAM) on row 0, live pixel on the last row.
      for (int r = 0; r < KERNEL_W - 1; r++) begin
        r_win[r][KERNEL_W-1] <= w_rd[KERNEL_W-2-r];
      end
      r_win[KERNEL_W-1][KERNEL_W-1] <= data_i;
      r_valid <= (w_x >= X_K1) && (w_y >= Y_K1);
      r_eol   <= w_eol;
      r_eof   <= w_eol && (w_y == Y_LAST);
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign window_o = r_win;
  assign valid_o  = r_valid;
  assign eol_o    = r_eol;
  assign eof_o    = r_eof;

endmodule
